rvx_input_conditioner: RTL and testbench

Multi-channel input conditioner for asynchronous board-level inputs such as reset/halt buttons, switches and GPIO pads. It replaces the single-flop registering in the board wrapper. Each channel gets a parametrised synchronizer chain, a stable-count debounce filter and registered rise/fall pulse outputs. It sits in the board wrapper between the pads and the `rvx` core's `reset`, `halt` and `gpio_input` ports.

---
 rtl/rvx_input_conditioner.sv | 74 +++++++
 tb/tb_rvx_input_conditioner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rvx_input_conditioner.sv
// Multi-channel input conditioner: per-channel synchronizer chain, stable-count
// debounce filter and registered rise/fall pulses for asynchronous board inputs.
module rvx_input_conditioner #(
    parameter int                    NUM_INPUTS      = 2,
    parameter int                    SYNC_STAGES     = 2,
    parameter int                    DEBOUNCE_CYCLES = 16,
    parameter logic [NUM_INPUTS-1:0] RESET_VALUE     = {NUM_INPUTS{1'b0}}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] raw_in,
    output logic [NUM_INPUTS-1:0] level,
    output logic [NUM_INPUTS-1:0] rise,
    output logic [NUM_INPUTS-1:0] fall
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    genvar i;
    generate
        for (i = 0; i < NUM_INPUTS; i++) begin : g_chan
            logic [SYNC_STAGES-1:0] sync_chain;
            logic                   sync;
            logic [CNT_W-1:0]       count;
            logic                   level_q;
            logic                   rise_q;
            logic                   fall_q;
            logic                   accept;

            assign sync   = sync_chain[SYNC_STAGES-1];
            assign accept = (sync != level_q) && (count == CNT_LAST);

            // Plain shift chain: nothing may sit between stages of a synchronizer.
            always_ff @(posedge clock) begin
                if (reset) begin
                    sync_chain <= {SYNC_STAGES{RESET_VALUE[i]}};
                end else begin
                    sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw_in[i]};
                end
            end

            // Any sample agreeing with the current level discards the partial count.
            always_ff @(posedge clock) begin
                if (reset) begin
                    count <= '0;
                end else if ((sync == level_q) || accept) begin
                    count <= '0;
                end else begin
                    count <= count + 1'b1;
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    level_q <= RESET_VALUE[i];
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    if (accept) begin
                        level_q <= sync;
                    end
                    rise_q <= accept & sync;
                    fall_q <= accept & ~sync;
                end
            end

            assign level[i] = level_q;
            assign rise[i]  = rise_q;
            assign fall[i]  = fall_q;
        end
    endgenerate

endmodule

// File: tb/tb_rvx_input_conditioner.sv
// Directed bench for rvx_input_conditioner: a per-cycle vector table for the
// main debounce behaviour plus hand-written reset and no-filter sequences.
module tb_rvx_input_conditioner;

    localparam int         SYNC = 2;
    localparam int         DEB  = 4;
    localparam int         LAT  = SYNC + DEB - 1;
    localparam logic [1:0] RV   = 2'b10;

    typedef struct {
        logic       rst;
        logic [1:0] raw;
        logic [1:0] level;
        logic [1:0] rise;
        logic [1:0] fall;
        int         test;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] raw_in;
    logic [1:0] raw_b;
    logic [1:0] level, rise, fall;
    logic [1:0] level_b, rise_b, fall_b;

    int checks = 0;
    int errors = 0;
    int cur_test = 0;
    vec_t vecs[$];

    rvx_input_conditioner #(
        .NUM_INPUTS(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .RESET_VALUE(RV)
    ) dut (
        .clock(clock), .reset(reset), .raw_in(raw_in),
        .level(level), .rise(rise), .fall(fall)
    );

    rvx_input_conditioner #(
        .NUM_INPUTS(2), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(1), .RESET_VALUE(RV)
    ) dut_b (
        .clock(clock), .reset(reset), .raw_in(raw_b),
        .level(level_b), .rise(rise_b), .fall(fall_b)
    );

    always #5 clock = ~clock;

    function automatic void add_row(input logic rst, input logic [1:0] raw,
                                    input logic [1:0] lvl, input logic [1:0] r,
                                    input logic [1:0] f);
        vec_t v;
        v.rst   = rst;
        v.raw   = raw;
        v.level = lvl;
        v.rise  = r;
        v.fall  = f;
        v.test  = cur_test;
        vecs.push_back(v);
    endfunction

    // Input held from row 0; the new level and its pulse appear after edge LAT.
    function automatic void add_segment(input logic [1:0] raw, input int rows,
                                        input logic [1:0] old_lvl,
                                        input logic [1:0] new_lvl);
        for (int k = 0; k < rows; k++) begin
            if (k < LAT)
                add_row(1'b0, raw, old_lvl, 2'b00, 2'b00);
            else if (k == LAT)
                add_row(1'b0, raw, new_lvl, ~old_lvl & new_lvl, old_lvl & ~new_lvl);
            else
                add_row(1'b0, raw, new_lvl, 2'b00, 2'b00);
        end
    endfunction

    task automatic applyStimulus(input logic rst, input logic [1:0] raw,
                                 input logic [1:0] rawb);
        @(negedge clock);
        reset  = rst;
        raw_in = raw;
        raw_b  = rawb;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name,
                               input logic [1:0] act_level, input logic [1:0] act_rise,
                               input logic [1:0] act_fall, input logic [1:0] exp_level,
                               input logic [1:0] exp_rise, input logic [1:0] exp_fall);
        checks += 4;
        if (act_level !== exp_level) begin
            errors++;
            $display("[TB] FAIL %s level: got %b expected %b", name, act_level, exp_level);
        end
        if (act_rise !== exp_rise) begin
            errors++;
            $display("[TB] FAIL %s rise: got %b expected %b", name, act_rise, exp_rise);
        end
        if (act_fall !== exp_fall) begin
            errors++;
            $display("[TB] FAIL %s fall: got %b expected %b", name, act_fall, exp_fall);
        end
        if ((act_rise & act_fall) !== 2'b00) begin
            errors++;
            $display("[TB] FAIL %s rise&fall overlap: got %b expected 00", name,
                     act_rise & act_fall);
        end
    endtask

    initial begin
        reset  = 1'b1;
        raw_in = RV;
        raw_b  = RV;

        // Test 1: reset held 3 cycles, then 20 idle cycles at the reset value.
        cur_test = 1;
        for (int k = 0; k < 3; k++) add_row(1'b1, 2'b10, 2'b10, 2'b00, 2'b00);
        for (int k = 0; k < 20; k++) add_row(1'b0, 2'b10, 2'b10, 2'b00, 2'b00);
        // Test 2: clean rising edge on channel 0, then back down.
        cur_test = 2;
        add_segment(2'b11, 8, 2'b10, 2'b11);
        add_segment(2'b10, 8, 2'b11, 2'b10);
        // Test 3: 3-cycle glitch rejected, then a held level accepted.
        cur_test = 3;
        for (int k = 0; k < 3; k++) add_row(1'b0, 2'b11, 2'b10, 2'b00, 2'b00);
        for (int k = 0; k < 6; k++) add_row(1'b0, 2'b10, 2'b10, 2'b00, 2'b00);
        add_segment(2'b11, 8, 2'b10, 2'b11);
        add_segment(2'b10, 8, 2'b11, 2'b10);
        // Test 4: both channels switch at the same edge.
        cur_test = 4;
        add_segment(2'b01, 8, 2'b10, 2'b01);

        for (int r = 0; r < vecs.size(); r++) begin
            applyStimulus(vecs[r].rst, vecs[r].raw, RV);
            checkOutput($sformatf("test%0d row%0d", vecs[r].test, r), level, rise, fall,
                        vecs[r].level, vecs[r].rise, vecs[r].fall);
        end

        // Test 5: reset one cycle mid-count abandons it; count restarts afterwards.
        applyStimulus(1'b1, 2'b10, RV);
        checkOutput("t5 reset", level, rise, fall, 2'b10, 2'b00, 2'b00);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 2'b11, RV);
            checkOutput($sformatf("t5 count e%0d", k), level, rise, fall, 2'b10, 2'b00, 2'b00);
        end
        applyStimulus(1'b1, 2'b11, RV);
        checkOutput("t5 mid reset", level, rise, fall, 2'b10, 2'b00, 2'b00);
        for (int k = 0; k < LAT; k++) begin
            applyStimulus(1'b0, 2'b11, RV);
            checkOutput($sformatf("t5 post f%0d", k), level, rise, fall, 2'b10, 2'b00, 2'b00);
        end
        applyStimulus(1'b0, 2'b11, RV);
        checkOutput("t5 accept", level, rise, fall, 2'b11, 2'b01, 2'b00);
        applyStimulus(1'b0, 2'b11, RV);
        checkOutput("t5 after", level, rise, fall, 2'b11, 2'b00, 2'b00);

        // Test 6: no filtering, a one-cycle pad pulse passes straight through.
        applyStimulus(1'b0, 2'b11, 2'b11);
        checkOutput("t6 e0", level_b, rise_b, fall_b, 2'b10, 2'b00, 2'b00);
        applyStimulus(1'b0, 2'b11, 2'b10);
        checkOutput("t6 e1", level_b, rise_b, fall_b, 2'b10, 2'b00, 2'b00);
        applyStimulus(1'b0, 2'b11, 2'b10);
        checkOutput("t6 e2", level_b, rise_b, fall_b, 2'b11, 2'b01, 2'b00);
        applyStimulus(1'b0, 2'b11, 2'b10);
        checkOutput("t6 e3", level_b, rise_b, fall_b, 2'b10, 2'b00, 2'b01);
        applyStimulus(1'b0, 2'b11, 2'b10);
        checkOutput("t6 e4", level_b, rise_b, fall_b, 2'b10, 2'b00, 2'b00);
        applyStimulus(1'b0, 2'b11, 2'b10);
        checkOutput("t6 e5", level_b, rise_b, fall_b, 2'b10, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
